serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: SLICE_W, 8, bits processed per clock; WIDTH SHALL be an integer multiple of SLICE_W.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port: start  input  1  request to begin a subtraction; sampled only when the block can accept a request.
REQ-006 Port: a  input  WIDTH  minuend, two's complement or unsigned.
REQ-007 Port: b  input  WIDTH  subtrahend.
REQ-008 Port: bin  input  1  borrow in; result is a - b - bin.
REQ-009 Port: diff  output  WIDTH  registered difference.
REQ-010 Port: bout  output  1  registered borrow out; 1 when unsigned a < b + bin.
REQ-011 Port: overflow  output  1  registered signed overflow flag.
REQ-012 Port: busy  output  1  high while a subtraction is in progress.
REQ-013 Port: done  output  1  one-cycle pulse; diff/bout/overflow are valid when high.

Function
REQ-014 States SHALL be IDLE, CALC, DONE; N = WIDTH/SLICE_W slice steps per operation.
REQ-015 IDLE or DONE with start=1 at an edge: latch a, b, bin; clear slice counter to 0; go to CALC.
REQ-016 IDLE with start=0: stay IDLE. DONE with start=0: go to IDLE.
REQ-017 CALC: each edge computes one slice, LSB slice first, as A_slice + ~B_slice + carry, initial carry = ~bin; carry chains between slices through a 1-bit register.
REQ-018 CALC: after slice N-1 is computed, go to DONE; diff, bout, overflow update on that same edge.
REQ-019 bout SHALL equal the inverse of the final slice carry-out.
REQ-020 overflow SHALL equal (a[WIDTH-1] != b[WIDTH-1]) AND (diff[WIDTH-1] != a[WIDTH-1]), using latched operands.
REQ-021 Latency: start sampled at edge k, so done is high in the cycle after edge k+N (N=4 with defaults); busy high during the N CALC cycles only.
REQ-022 done SHALL be high only in state DONE, for exactly one cycle per operation.
REQ-023 start while in CALC SHALL be ignored; the operation in progress and latched operands are unaffected.
REQ-024 start in the DONE cycle SHALL be accepted (back-to-back operation); done pulses once per operation with no idle gap required.
REQ-025 Changes to a, b or bin after the accept edge SHALL NOT affect the result.
REQ-026 diff, bout, overflow SHALL hold their last values until the next operation's final edge; they SHALL NOT show partial results mid-operation.

Reset
REQ-027 rst=1 at an edge: state IDLE; counter, carry, latched operands, diff, bout, overflow, busy, done all 0.
REQ-028 rst has priority over start and over CALC progress; reset mid-operation aborts it and no done pulse follows.
REQ-029 After rst is released, the first start SHALL behave as from IDLE.

Verification
REQ-030 a=5, b=3, bin=0, start at edge k: diff=0x00000002, bout=0, overflow=0, done in cycle after edge k+4, busy high 4 cycles.
REQ-031 a=0x00000000, b=0x00000001, bin=0: diff=0xFFFFFFFF, bout=1, overflow=0.
REQ-032 a=0x80000000, b=0x00000001, bin=0: diff=0x7FFFFFFF, bout=0, overflow=1; then a=0x7FFFFFFF, b=0xFFFFFFFF: diff=0x80000000, bout=1, overflow=1.
REQ-033 a=0x00000100, b=0x000000FF, bin=1 (borrow across slice boundary): diff=0x00000000, bout=0, overflow=0.
REQ-034 start pulsed in second CALC cycle with different operands: ignored, first result unchanged. start held high in DONE cycle: second operation accepted, two done pulses 4 cycles apart.
REQ-035 rst=1 in the third CALC cycle: all outputs 0 next cycle, no done pulse. A later start completes correctly.

Source files
------------

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: computes a - b - bin one SLICE_W-bit slice per clock,
// LSB slice first, with the inter-slice carry held in a 1-bit register.
module serial_subtractor #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SLICE_W:0] slice_sum;
    logic             last_slice;
    int               slice_base;

    assign last_slice = (cnt == LAST);

    // Subtraction as a + ~b + carry; the top bit of slice_sum is the carry into the next slice.
    always_comb begin
        slice_base = int'(cnt) * SLICE_W;
        slice_sum  = {1'b0, a_q[slice_base +: SLICE_W]}
                   + {1'b0, ~b_q[slice_base +: SLICE_W]}
                   + {{SLICE_W{1'b0}}, carry};
        acc_next   = acc;
        acc_next[slice_base +: SLICE_W] = slice_sum[SLICE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? CALC : IDLE;
            CALC:    state_next = last_slice ? DONE : CALC;
            DONE:    state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            CALC:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Results are only published on the final slice edge so diff never shows partial values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            diff     <= '0;
            bout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= ~bin;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    carry <= slice_sum[SLICE_W];
                    cnt   <= cnt + 1'b1;
                    if (last_slice) begin
                        diff     <= acc_next;
                        bout     <= ~slice_sum[SLICE_W];
                        overflow <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                    (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor: expected results are queued
// at stimulus time and checked with immediate assertions when done pulses.
module tb_serial_subtractor;

    localparam int WIDTH   = 32;
    localparam int SLICE_W = 8;
    localparam int N       = WIDTH / SLICE_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;
    logic             busy;
    logic             done;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] prev_diff;

    always #5 clk = ~clk;

    serial_subtractor #(
        .WIDTH  (WIDTH),
        .SLICE_W(SLICE_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .diff    (diff),
        .bout    (bout),
        .overflow(overflow),
        .busy    (busy),
        .done    (done)
    );

    task automatic check_output(input string tag, input logic [WIDTH-1:0] obs,
                                input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned borrow from a wide subtraction, overflow from the signed range.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic binv);
        exp_t                    m;
        logic [WIDTH:0]          u;
        logic signed [WIDTH+1:0] s;
        u = {1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, binv};
        s = $signed({{2{av[WIDTH-1]}}, av}) - $signed({{2{bv[WIDTH-1]}}, bv})
          - $signed({{(WIDTH+1){1'b0}}, binv});
        m.diff = u[WIDTH-1:0];
        m.bout = u[WIDTH];
        m.ovf  = !((s[WIDTH+1] == s[WIDTH]) && (s[WIDTH] == s[WIDTH-1]));
        return m;
    endfunction

    task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic binv);
        a     = av;
        b     = bv;
        bin   = binv;
        start = 1'b1;
        sb.push_back(model(av, bv, binv));
    endtask

    // Follows one operation from its accept edge to done; optionally pulses start mid-CALC
    // and optionally launches the next operation in the DONE cycle.
    task automatic wait_done(input string tag, input int inject, input bit chain,
                             input logic [WIDTH-1:0] ca, input logic [WIDTH-1:0] cb,
                             input logic cbin);
        int   busy_cnt = 0;
        int   lat      = -1;
        exp_t e;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
                bin   = 1'($urandom_range(0, 1));
            end
            if (j == inject) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end
            if (j == inject + 1) start = 1'b0;
            if (j == 1) check_output({tag, " hold"}, diff, prev_diff);
            if (done) begin
                lat = j;
                break;
            end
            if (busy) busy_cnt++;
        end
        check_output({tag, " latency"}, WIDTH'(lat), WIDTH'(N));
        check_output({tag, " busy_cycles"}, WIDTH'(busy_cnt), WIDTH'(N));
        if (sb.size() == 0) begin
            check_output({tag, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (lat >= 0) begin
                check_output({tag, " diff"}, diff, e.diff);
                check_output({tag, " bout"}, WIDTH'(bout), WIDTH'(e.bout));
                check_output({tag, " overflow"}, WIDTH'(overflow), WIDTH'(e.ovf));
                check_output({tag, " busy_in_done"}, WIDTH'(busy), 0);
                prev_diff = e.diff;
            end
        end
        if (chain) begin
            apply_stimulus(ca, cb, cbin);
        end else begin
            @(negedge clk);
            check_output({tag, " done_single"}, WIDTH'(done), 0);
        end
    endtask

    initial begin
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset diff", diff, 0);
        check_output("reset bout", WIDTH'(bout), 0);
        check_output("reset overflow", WIDTH'(overflow), 0);
        check_output("reset busy", WIDTH'(busy), 0);
        check_output("reset done", WIDTH'(done), 0);
        rst       = 1'b0;
        prev_diff = '0;
        @(negedge clk);

        $display("[TB] basic and boundary subtractions");
        apply_stimulus(32'd5, 32'd3, 1'b0);
        wait_done("sub_5_3", -1, 1'b0, '0, '0, 1'b0);
        apply_stimulus(32'h0000_0000, 32'h0000_0001, 1'b0);
        wait_done("sub_0_1", -1, 1'b0, '0, '0, 1'b0);
        apply_stimulus(32'h8000_0000, 32'h0000_0001, 1'b0);
        wait_done("ovf_neg", -1, 1'b0, '0, '0, 1'b0);
        apply_stimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("ovf_pos", -1, 1'b0, '0, '0, 1'b0);
        apply_stimulus(32'h0000_0100, 32'h0000_00FF, 1'b1);
        wait_done("slice_borrow", -1, 1'b0, '0, '0, 1'b0);

        $display("[TB] start ignored in CALC, then back-to-back");
        apply_stimulus(32'd10, 32'd4, 1'b0);
        wait_done("ignore_start", 1, 1'b1, 32'h1234_5678, 32'h0123_4567, 1'b1);
        wait_done("back_to_back", -1, 1'b0, '0, '0, 1'b0);
        apply_stimulus($urandom, $urandom, 1'b1);
        wait_done("random", -1, 1'b0, '0, '0, 1'b0);

        $display("[TB] reset during CALC");
        apply_stimulus(32'h0000_DEAD, 32'h0000_BEEF, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort diff", diff, 0);
        check_output("abort bout", WIDTH'(bout), 0);
        check_output("abort overflow", WIDTH'(overflow), 0);
        check_output("abort busy", WIDTH'(busy), 0);
        check_output("abort done", WIDTH'(done), 0);
        rst = 1'b0;
        void'(sb.pop_front());
        prev_diff = '0;
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_output("abort no_done", WIDTH'(done_seen), 0);
        apply_stimulus(32'd100, 32'd58, 1'b0);
        wait_done("after_reset", -1, 1'b0, '0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
